// File: rtl/tlc_phase_scheduler.sv
// Traffic light phase scheduler.
// Shares the intersection among the farm-road sensor, the pedestrian walk
// button and the emergency preempt. One phase timer drives every interval:
// it clears on each state change, otherwise counts up and saturates.
// All light/grant outputs are registered and follow the state register.
module tlc_phase_scheduler #(
  parameter int GREEN_MIN_HWY = 30,
  parameter int GREEN_FARM    = 15,
  parameter int YELLOW_T      = 3,
  parameter int ALLRED_T      = 2,
  parameter int WALK_T        = 10,
  parameter int CW            = 31
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       farmReq,
  input  logic       pedReq,
  input  logic       emgReq,
  output logic [1:0] highwaySignal,
  output logic [1:0] farmSignal,
  output logic       walkSignal,
  output logic [1:0] grant,
  output logic [2:0] state,
  output logic       pedPending
);

  typedef enum logic [2:0] {
    S_HG     = 3'd0,
    S_HY     = 3'd1,
    S_AR_OUT = 3'd2,
    S_FG     = 3'd3,
    S_FY     = 3'd4,
    S_AR_IN  = 3'd5,
    S_WALK   = 3'd6,
    S_EMG    = 3'd7
  } state_t;

  // Light encoding shared by both roads.
  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;

  // Grant encoding.
  localparam logic [1:0] G_HWY  = 2'b00;
  localparam logic [1:0] G_FARM = 2'b01;
  localparam logic [1:0] G_PED  = 2'b10;
  localparam logic [1:0] G_EMG  = 2'b11;

  // An interval of N cycles ends on the edge where the timer reads N-1.
  localparam logic [CW-1:0] C_HG_MIN = CW'(GREEN_MIN_HWY - 1);
  localparam logic [CW-1:0] C_FARM   = CW'(GREEN_FARM - 1);
  localparam logic [CW-1:0] C_YEL    = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] C_AR     = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] C_WALK   = CW'(WALK_T - 1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  state_t        r_state;
  logic [CW-1:0] r_timer;
  logic          r_ped_pending;
  logic          r_last_ped;      // 1: pedestrian was served last, farm wins a tie
  logic [1:0]    r_hwy;
  logic [1:0]    r_farm;
  logic          r_walk;
  logic [1:0]    r_grant;

  state_t        w_state_next;
  logic          w_state_change;
  logic          w_timer_sat;
  logic          w_enter_walk;
  logic          w_enter_fg;
  logic [1:0]    w_hwy_next;
  logic [1:0]    w_farm_next;
  logic          w_walk_next;
  logic [1:0]    w_grant_next;

  assign w_state_change = (w_state_next != r_state);
  assign w_timer_sat    = &r_timer;
  assign w_enter_walk   = (w_state_next == S_WALK) && (r_state != S_WALK);
  assign w_enter_fg     = (w_state_next == S_FG) && (r_state != S_FG);

  // Next-state selection; yellow and all-red are left only on timer expiry.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HG: begin
        if (emgReq || ((r_timer >= C_HG_MIN) && (farmReq || r_ped_pending)))
          w_state_next = S_HY;
      end
      S_HY: begin
        if (r_timer == C_YEL)
          w_state_next = S_AR_OUT;
      end
      S_AR_OUT: begin
        if (r_timer == C_AR) begin
          if (emgReq)
            w_state_next = S_EMG;
          else if (farmReq && r_ped_pending)
            w_state_next = r_last_ped ? S_FG : S_WALK;
          else if (farmReq)
            w_state_next = S_FG;
          else if (r_ped_pending)
            w_state_next = S_WALK;
          else
            w_state_next = S_HG;   // request withdrawn during clearance
        end
      end
      S_FG: begin
        if (emgReq || (r_timer == C_FARM))
          w_state_next = S_FY;
      end
      S_FY: begin
        if (r_timer == C_YEL)
          w_state_next = S_AR_IN;
      end
      S_WALK: begin
        // Vehicles are already red, so preemption can go straight to EMG.
        if (emgReq)
          w_state_next = S_EMG;
        else if (r_timer == C_WALK)
          w_state_next = S_AR_IN;
      end
      S_AR_IN: begin
        if (r_timer == C_AR)
          w_state_next = emgReq ? S_EMG : S_HG;
      end
      S_EMG: begin
        if (!emgReq)
          w_state_next = S_AR_IN;
      end
      default: w_state_next = S_HG;
    endcase
  end

  // Moore decode of the lamps and grant for the state about to be entered.
  always_comb begin
    w_hwy_next   = L_RED;
    w_farm_next  = L_RED;
    w_walk_next  = 1'b0;
    w_grant_next = G_HWY;
    case (w_state_next)
      S_HG:     w_hwy_next = L_GRN;
      S_HY:     w_hwy_next = L_YEL;
      S_AR_OUT: w_grant_next = G_HWY;
      S_FG: begin
        w_farm_next  = L_GRN;
        w_grant_next = G_FARM;
      end
      S_FY: begin
        w_farm_next  = L_YEL;
        w_grant_next = G_FARM;
      end
      S_AR_IN:  w_grant_next = G_HWY;
      S_WALK: begin
        w_walk_next  = 1'b1;
        w_grant_next = G_PED;
      end
      S_EMG:    w_grant_next = G_EMG;
      default:  w_hwy_next = L_GRN;
    endcase
  end

  // State, phase timer, pedestrian latch, round-robin flag and outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= S_HG;
      r_timer       <= '0;
      r_ped_pending <= 1'b0;
      r_last_ped    <= 1'b1;
      r_hwy         <= L_GRN;
      r_farm        <= L_RED;
      r_walk        <= 1'b0;
      r_grant       <= G_HWY;
    end else begin
      r_state <= w_state_next;

      if (w_state_change)
        r_timer <= '0;
      else if (!w_timer_sat)
        r_timer <= r_timer + C_ONE;

      // A press on the WALK-entry edge stays pending: set beats clear.
      if (pedReq)
        r_ped_pending <= 1'b1;
      else if (w_enter_walk)
        r_ped_pending <= 1'b0;

      if (w_enter_fg)
        r_last_ped <= 1'b0;
      else if (w_enter_walk)
        r_last_ped <= 1'b1;

      r_hwy   <= w_hwy_next;
      r_farm  <= w_farm_next;
      r_walk  <= w_walk_next;
      r_grant <= w_grant_next;
    end
  end

  assign highwaySignal = r_hwy;
  assign farmSignal    = r_farm;
  assign walkSignal    = r_walk;
  assign grant         = r_grant;
  assign state         = r_state;
  assign pedPending    = r_ped_pending;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler with short phase durations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tlc_phase_scheduler;

  localparam logic [2:0] HG     = 3'd0;
  localparam logic [2:0] HY     = 3'd1;
  localparam logic [2:0] AR_OUT = 3'd2;
  localparam logic [2:0] FG     = 3'd3;
  localparam logic [2:0] FY     = 3'd4;
  localparam logic [2:0] AR_IN  = 3'd5;
  localparam logic [2:0] WALK   = 3'd6;
  localparam logic [2:0] EMG    = 3'd7;

  logic       Clk;
  logic       Rst;
  logic       farmReq;
  logic       pedReq;
  logic       emgReq;
  logic [1:0] highwaySignal;
  logic [1:0] farmSignal;
  logic       walkSignal;
  logic [1:0] grant;
  logic [2:0] state;
  logic       pedPending;

  int n_tests;
  int n_fail;

  // Narrow timer so the idle run reaches saturation quickly.
  tlc_phase_scheduler #(
    .GREEN_MIN_HWY(8),
    .GREEN_FARM   (5),
    .YELLOW_T     (3),
    .ALLRED_T     (2),
    .WALK_T       (4),
    .CW           (5)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .farmReq      (farmReq),
    .pedReq       (pedReq),
    .emgReq       (emgReq),
    .highwaySignal(highwaySignal),
    .farmSignal   (farmSignal),
    .walkSignal   (walkSignal),
    .grant        (grant),
    .state        (state),
    .pedPending   (pedPending)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Expected {highway, farm, walk, grant} for each state code.
  function automatic logic [6:0] exp_out(input logic [2:0] code);
    case (code)
      HG:      return 7'b10_00_0_00;
      HY:      return 7'b01_00_0_00;
      AR_OUT:  return 7'b00_00_0_00;
      FG:      return 7'b00_10_0_01;
      FY:      return 7'b00_01_0_01;
      AR_IN:   return 7'b00_00_0_00;
      WALK:    return 7'b00_00_1_10;
      default: return 7'b00_00_0_11;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expect `code` (and its lamps) for n consecutive cycles; pend < 0 skips pedPending.
  task automatic run_state(input string tag, input logic [2:0] code, input int n, input int pend);
    $display("[TB] %s: expect state %0d for %0d cycles", tag, code, n);
    for (int i = 0; i < n; i++) begin
      check({tag, "/state"}, 8'(state), 8'(code));
      check({tag, "/lamps"}, 8'({highwaySignal, farmSignal, walkSignal, grant}), 8'(exp_out(code)));
      if (pend >= 0)
        check({tag, "/pend"}, 8'(pedPending), 8'(pend));
      @(negedge Clk);
    end
  endtask

  task automatic do_reset();
    Rst     = 1'b1;
    farmReq = 1'b0;
    pedReq  = 1'b0;
    emgReq  = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // 1. Reset values, then a long idle stretch past timer saturation.
    do_reset();
    check("rst/state", 8'(state), 8'(HG));
    check("rst/lamps", 8'({highwaySignal, farmSignal, walkSignal, grant}), 8'(7'b10_00_0_00));
    check("rst/pend",  8'(pedPending), 8'(0));
    run_state("idle_hg", HG, 200, 0);
    // Saturated timer still satisfies minimum green: HY after one edge.
    farmReq = 1'b1;
    @(negedge Clk);
    farmReq = 1'b0;
    run_state("sat_hy", HY, 3, 0);
    // Request withdrawn during clearance: back to highway green.
    run_state("wd_ar", AR_OUT, 2, 0);
    run_state("wd_hg", HG, 1, 0);

    // 2. Farm request held.
    do_reset();
    farmReq = 1'b1;
    run_state("farm_hg", HG, 8, 0);
    run_state("farm_hy", HY, 3, 0);
    run_state("farm_aro", AR_OUT, 2, 0);
    run_state("farm_fg", FG, 5, 0);
    run_state("farm_fy", FY, 3, 0);
    run_state("farm_ari", AR_IN, 2, 0);
    run_state("farm_hg2", HG, 1, 0);
    farmReq = 1'b0;

    // 3. One-cycle pedestrian press.
    do_reset();
    @(negedge Clk);
    pedReq = 1'b1;
    @(negedge Clk);
    pedReq = 1'b0;
    run_state("ped_hg", HG, 6, 1);
    run_state("ped_hy", HY, 3, 1);
    run_state("ped_aro", AR_OUT, 2, 1);
    run_state("ped_walk", WALK, 4, 0);
    run_state("ped_ari", AR_IN, 2, 0);
    run_state("ped_hg2", HG, 1, 0);

    // 4. Farm and pedestrian both held: alternate, farm first.
    do_reset();
    farmReq = 1'b1;
    pedReq  = 1'b1;
    run_state("rr_hg", HG, 8, -1);
    run_state("rr_hy", HY, 3, 1);
    run_state("rr_aro", AR_OUT, 2, 1);
    run_state("rr_fg", FG, 5, 1);
    run_state("rr_fy", FY, 3, 1);
    run_state("rr_ari", AR_IN, 2, 1);
    run_state("rr_hg2", HG, 8, 1);
    run_state("rr_hy2", HY, 3, 1);
    run_state("rr_aro2", AR_OUT, 2, 1);
    // Press held through the WALK-entry edge keeps the request pending.
    run_state("rr_walk", WALK, 4, 1);
    run_state("rr_ari2", AR_IN, 2, 1);
    run_state("rr_hg3", HG, 8, 1);
    run_state("rr_hy3", HY, 3, 1);
    run_state("rr_aro3", AR_OUT, 2, 1);
    run_state("rr_fg2", FG, 1, 1);
    farmReq = 1'b0;
    pedReq  = 1'b0;

    // 5. Emergency truncates farm green at timer 1, held for 10 edges.
    do_reset();
    farmReq = 1'b1;
    run_state("emg_hg", HG, 8, 0);
    run_state("emg_hy", HY, 3, 0);
    run_state("emg_aro", AR_OUT, 2, 0);
    run_state("emg_fg", FG, 1, 0);
    check("emg_fg1/state", 8'(state), 8'(FG));
    emgReq  = 1'b1;
    farmReq = 1'b0;
    @(negedge Clk);
    run_state("emg_fy", FY, 3, 0);
    run_state("emg_ari", AR_IN, 2, 0);
    run_state("emg_hold", EMG, 4, 0);
    emgReq = 1'b0;
    run_state("emg_last", EMG, 1, 0);
    run_state("emg_ari2", AR_IN, 2, 0);
    run_state("emg_hg2", HG, 1, 0);
    // Emergency in HG ignores minimum green; yellow is not truncated.
    emgReq = 1'b1;
    @(negedge Clk);
    run_state("emgh_hy", HY, 3, 0);
    run_state("emgh_aro", AR_OUT, 2, 0);
    run_state("emgh_emg", EMG, 1, 0);
    emgReq = 1'b0;
    run_state("emgh_emg2", EMG, 1, 0);
    run_state("emgh_ari", AR_IN, 1, 0);

    // 6. Reset during farm yellow with a pedestrian request pending.
    do_reset();
    farmReq = 1'b1;
    @(negedge Clk);
    pedReq = 1'b1;
    @(negedge Clk);
    pedReq = 1'b0;
    run_state("mid_hg", HG, 6, 1);
    run_state("mid_hy", HY, 3, 1);
    run_state("mid_aro", AR_OUT, 2, 1);
    run_state("mid_fg", FG, 5, 1);
    run_state("mid_fy", FY, 1, 1);
    check("mid_fy1/state", 8'(state), 8'(FY));
    Rst = 1'b1;
    @(negedge Clk);
    $display("[TB] mid_rst: reset asserted in FY");
    check("mid_rst/state", 8'(state), 8'(HG));
    check("mid_rst/pend",  8'(pedPending), 8'(0));
    check("mid_rst/lamps", 8'({highwaySignal, farmSignal, walkSignal, grant}), 8'(7'b10_00_0_00));
    Rst     = 1'b0;
    farmReq = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
